// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared stage type, parity helper and depth bound for dff_pipe (parity under DFF_PIPE_PARITY_EN)
package dff_pipe_pkg;
   localparam int DFF_PIPE_WIDTH = 8;
   localparam int DFF_PIPE_MAX_DEPTH = 64;
   typedef struct packed {
      logic valid;
      logic [DFF_PIPE_WIDTH-1:0] data;
`ifdef DFF_PIPE_PARITY_EN
      logic parity;
`endif
   } stage_t;
   function automatic logic even_parity(input logic [63:0] x);
      return ^x;
   endfunction
endpackage

// File: rtl/dff_pipe_assertions.sv
// dff_pipe_assertions: output stability and occupancy invariants, bound into dff_pipe
module dff_pipe_assertions import dff_pipe_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input logic             clk,
   input logic             rst,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH-1:0] out_data,
   input logic [CNT_W-1:0] count,
   input logic [DEPTH-1:0] v
);
   a_hold: assert property (@(posedge clk) disable iff (rst) out_valid && !out_ready |=> $stable(out_data));
   a_max:  assert property (@(posedge clk) disable iff (rst) int'(count) <= DEPTH && DEPTH <= DFF_PIPE_MAX_DEPTH);
   a_pop:  assert property (@(posedge clk) disable iff (rst) int'(count) == $countones(v));
endmodule

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one elastic register stage with valid and ready to upstream
module dff_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_v,
   input  logic [W-1:0] in_d,
   input  logic         rdy_dn,
   output logic         out_v,
   output logic [W-1:0] out_d,
   output logic         rdy_up
);
   assign rdy_up = !out_v || rdy_dn;
   // data moves only with a live beat so an empty stage never disturbs what it presents
   always_ff @(posedge clk)
      if (rst) begin
         out_v <= 1'b0;
         out_d <= '0;
      end else begin
         out_v <= (rdy_up ? in_v : out_v) && !flush;
         if (rdy_up && in_v && !flush) out_d <= in_d;
      end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage elastic register pipeline with flush and occupancy count (parity under DFF_PIPE_PARITY_EN)
module dff_pipe import dff_pipe_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
`ifdef DFF_PIPE_PARITY_EN
   ,
   output logic             parity_err
`endif
);
`ifdef DFF_PIPE_PARITY_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif
   logic [DEPTH:0] vc, rc;
   logic [SW-1:0]  dc [DEPTH+1];
   logic           in_xfer, out_xfer;
   assign vc[0] = in_valid;
   assign rc[DEPTH] = out_ready;
`ifdef DFF_PIPE_PARITY_EN
   assign dc[0] = {even_parity(64'(in_data)), in_data};
`else
   assign dc[0] = in_data;
`endif
   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_st
         dff_pipe_stage #(.W(SW)) u_st (
            .clk(clk), .rst(rst), .flush(flush),
            .in_v(vc[i]), .in_d(dc[i]), .rdy_dn(rc[i+1]),
            .out_v(vc[i+1]), .out_d(dc[i+1]), .rdy_up(rc[i])
         );
      end
   endgenerate
   assign in_ready  = rc[0] && !flush;
   assign out_valid = vc[DEPTH];
   assign out_data  = dc[DEPTH][WIDTH-1:0];
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   // occupancy follows accepted minus emitted beats
   always_ff @(posedge clk)
      if (rst || flush) count <= '0;
      else count <= count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
`ifdef DFF_PIPE_PARITY_EN
   // one-cycle flag for an emitted beat whose data no longer matches its stored parity
   always_ff @(posedge clk)
      if (rst || flush) parity_err <= 1'b0;
      else parity_err <= out_xfer && (even_parity(64'(out_data)) != dc[DEPTH][WIDTH]);
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed self-checking bench for dff_pipe
bind dff_pipe dff_pipe_assertions #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_asrt (
   .clk(clk), .rst(rst), .out_valid(out_valid), .out_ready(out_ready),
   .out_data(out_data), .count(count), .v(vc[DEPTH:1])
);

module tb_dff_pipe;
   logic       clk = 1'b0;
   logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data;
   logic [2:0] count;
`ifdef DFF_PIPE_PARITY_EN
   logic       parity_err;
`endif
   int         checks = 0;
   int         errors = 0;
   logic [7:0] bp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   dff_pipe #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count)
`ifdef DFF_PIPE_PARITY_EN
      , .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_valid", 32'(out_valid), 0);
         chk("rst_count", 32'(count), 0);
      end
      chk("rst_data", 32'(out_data), 0);
      rst = 1'b0; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      chk("lat_count", 32'(count), 1);
      chk("lat_v1", 32'(out_valid), 0);
      tick();
      chk("lat_v2", 32'(out_valid), 0);
      tick();
      chk("lat_v3", 32'(out_valid), 0);
      tick();
      chk("lat_v4", 32'(out_valid), 1);
      chk("lat_data", 32'(out_data), 32'hA5);
      out_ready = 1'b1;
      tick();
      chk("lat_drain_v", 32'(out_valid), 0);
      chk("lat_drain_cnt", 32'(count), 0);

      in_valid = 1'b1; in_data = 8'h00;
      for (int j = 1; j <= 20; j++) begin
         int ein, eout;
         tick();
         if (j < 16) in_data = 8'(j);
         if (j == 16) in_valid = 1'b0;
         ein  = (j < 16) ? j : 16;
         eout = ((j < 20 ? j : 20) > 4) ? (j < 20 ? j : 20) - 4 : 0;
         chk("str_count", 32'(count), 32'(ein - eout));
         chk("str_valid", 32'(out_valid), 32'(j >= 4 && j <= 19));
         if (j >= 4 && j <= 19) chk("str_data", 32'(out_data), 32'(j - 4));
      end

      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = bp[k];
         #1;
         chk("bp_rdy_fill", 32'(in_ready), 1);
         tick();
      end
      in_data = bp[4];
      #1;
      chk("bp_rdy_full", 32'(in_ready), 0);
      chk("bp_count", 32'(count), 4);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h11);
      repeat (2) begin
         tick();
         chk("bp_hold_rdy", 32'(in_ready), 0);
         chk("bp_hold_data", 32'(out_data), 32'h11);
         chk("bp_hold_cnt", 32'(count), 4);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_release", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_out_data", 32'(out_data), 32'(bp[k]));
         chk("bp_out_cnt", 32'(count), 32'(5 - k));
         tick();
      end
      chk("bp_empty_v", 32'(out_valid), 0);
      chk("bp_empty_cnt", 32'(count), 0);

      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 8'(8'h60 + k);
         tick();
      end
      in_data = 8'h64; out_ready = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         #1;
         chk("sim_rdy", 32'(in_ready), 1);
         tick();
         chk("sim_count", 32'(count), 4);
         chk("sim_data", 32'(out_data), 32'(8'h60 + n));
         in_data = 8'(8'h64 + n);
      end
      in_valid = 1'b0;
      repeat (4) tick();
      chk("sim_drain_cnt", 32'(count), 0);
      chk("sim_drain_v", 32'(out_valid), 0);

      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = 8'(8'h31 + k);
         tick();
      end
      chk("fl_pre_cnt", 32'(count), 3);
      chk("fl_pre_v", 32'(out_valid), 0);
      flush = 1'b1; in_data = 8'h99;
      #1;
      chk("fl_rdy", 32'(in_ready), 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_cnt", 32'(count), 0);
      chk("fl_v", 32'(out_valid), 0);
      repeat (8) begin
         tick();
         chk("fl_stale", 32'(out_valid), 0);
      end
      chk("fl_end_cnt", 32'(count), 0);

`ifdef DFF_PIPE_PARITY_EN
      in_valid = 1'b1; in_data = 8'h0F;
      tick();
      in_valid = 1'b0;
      chk("par_idle", 32'(parity_err), 0);
      tick();
      tick();
      force dut.g_st[2].u_st.out_d = 9'h00E;
      #1;
      release dut.g_st[2].u_st.out_d;
      tick();
      chk("par_out_v", 32'(out_valid), 1);
      chk("par_out_data", 32'(out_data), 32'h0E);
      chk("par_before", 32'(parity_err), 0);
      tick();
      chk("par_pulse", 32'(parity_err), 1);
      tick();
      chk("par_clear", 32'(parity_err), 0);
      in_valid = 1'b1; in_data = 8'h5A;
      tick();
      in_valid = 1'b0;
      repeat (5) begin
         tick();
         chk("par_clean", 32'(parity_err), 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised elastic register pipeline, the successor to the single dff block: DEPTH stages of WIDTH-bit registers with per-stage valid and a valid/ready handshake. It supports backpressure, flush, and an occupancy count. It sits between producer and consumer blocks wherever registered, stall-tolerant latency is needed. It is verified in the same interface/bench/assertion-bind style as dff.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1); this is also the no-stall latency
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  clear all stages at the next edge
in_valid  input  1  producer has a beat
in_data  input  WIDTH  producer data
in_ready  output  1  pipeline accepts a beat this cycle
out_valid  output  1  last stage holds a beat
out_data  output  WIDTH  last stage data
out_ready  input  1  consumer accepts a beat this cycle
count  output  CNT_W  number of valid stages, 0..DEPTH

Behaviour:
- Reset (rst=1 at a rising edge): every stage valid=0 and data=0. Gives out_valid=0, out_data=0, count=0. rst has priority over flush and all traffic.
- Stage i state: v[i], d[i]. Stage DEPTH-1 drives out_valid/out_data directly from registers; no combinational path from in_data to out_data.
- Ready chain (combinational): rdy[DEPTH-1] = !v[DEPTH-1] || out_ready; rdy[i] = !v[i] || rdy[i+1].
- in_ready = rdy[0] && !flush.
- Stage 0 loads when rdy[0]: d[0]<=in_data and v[0]<=in_valid&&!flush. Stage i>0 loads when rdy[i]: d[i]<=d[i-1] and v[i]<=v[i-1].
- Data registers hold when the stage is not ready. Data of an invalid stage is don't-care, but it must not change out_data while out_valid=0 and out_ready=0.
- Handshakes: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. Once out_valid=1, out_data stays stable until the transfer completes.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+DEPTH-1 (visible in cycle N+DEPTH), provided there are no stalls.
- Throughput: 1 beat/cycle sustained when out_ready=1. A full pipeline with out_ready=1 accepts and emits in the same cycle (bubbles collapse).
- Backpressure: with out_ready=0, bubbles are squeezed out until all DEPTH stages are valid, then in_ready=0.
- flush=1: all v[] go to 0 at the edge. An input beat presented that cycle is not accepted (in_ready=0). An output transfer that cycle still completes (consumer sees it once). count becomes 0.
- count: registered. Updates as count + in_xfer - out_xfer, or to 0 on flush/rst. It always equals the population count of v[].
- DEPTH=1 behaves as a single skid-free register stage: in_ready = !v || out_ready.

Optional Feature:
- Macro: DFF_PIPE_PARITY_EN.
- Defined: each stage stores an extra even-parity bit computed from in_data at stage 0 and carried with the data. A registered output parity_err (1 bit) pulses high for one cycle, on the cycle after an output transfer whose recomputed parity mismatches the stored bit. It resets to 0 and is cleared by flush.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Package dff_pipe_pkg:
  - typedef stage_t struct {valid, data[WIDTH], parity (under macro)}, with WIDTH as a package-level default;
  - function even_parity;
  - constant DFF_PIPE_MAX_DEPTH=64 for assertion bounds.
- Sub-module dff_pipe_stage: one register stage (in v/d, downstream ready, flush, out v/d, ready to upstream). dff_pipe generates DEPTH instances in a generate loop.
- Assertions (bound module dff_pipe_assertions) cover:
  - out_data stable while out_valid && !out_ready;
  - count <= DEPTH;
  - count == $countones(v).

Test Plan:
- Reset: hold rst=1 for 10 cycles with in_valid=1 -> out_valid=0, count=0, in_ready irrelevant; after release, first beat 0xA5 appears at out after exactly DEPTH=4 cycles.
- Streaming: 16 beats 0x00..0x0F, out_ready=1 -> outputs 0x00..0x0F in order, 1/cycle, count settles at 4, no gaps.
- Backpressure: out_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> in_ready drops after 4 accepted, count=4, out_data=0x11 stable. Raise out_ready -> 0x11..0x44 then 0x55 accepted and emitted.
- Simultaneous: pipeline full, out_ready=1 and in_valid=1 every cycle -> in_ready=1 throughout, count stays 4.
- Flush mid-stream: after 3 beats accepted, assert flush with in_valid=1 (data 0x99) -> 0x99 not accepted, next cycle count=0, out_valid=0, no stale beat emerges in the following 8 cycles.
- Parity (DFF_PIPE_PARITY_EN): force a flipped data bit in stage 2 via bench hook -> parity_err=1 for exactly one cycle after that beat transfers out. Unmodified beats give parity_err=0.
